// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC register and instruction fetch stage with req/ready memory handshake
// Optional IFU_PERF_EN adds retired-instruction and fetch-wait counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
`ifdef IFU_PERF_EN
    output logic [31:0] retired_cnt,
    output logic [31:0] wait_cnt,
`endif
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [7:0]  r_wait;
    logic [7:0]  w_wait_next;
    logic        w_load_instr;
    logic        w_take_adv;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    // Jump beats branch; a branch without zero falls through.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (branch && zero) begin
            w_next_pc = w_pc_plus4 + w_br_off;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_wait_next  = r_wait;
        w_load_instr = 1'b0;
        w_take_adv   = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_next_state = S_FETCH;
                w_wait_next  = 8'd0;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    w_next_state = S_VALID;
                    w_load_instr = 1'b1;
                    w_wait_next  = 8'd0;
                end else begin
                    w_wait_next = r_wait + 8'd1;
                    if (r_wait == WAIT_LAST) begin
                        w_next_state = S_ERR;
                    end
                end
            end
            S_VALID: begin
                if (advance) begin
                    w_next_state = S_FETCH;
                    w_take_adv   = 1'b1;
                    w_wait_next  = 8'd0;
                end
            end
            S_ERR: begin
                w_next_state = S_ERR;
            end
            default: begin
                w_next_state = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_wait  <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_wait  <= w_wait_next;
            if (w_load_instr) begin
                r_instr <= imem_rdata;
            end
            if (w_take_adv) begin
                r_pc <= {w_next_pc[31:2], 2'b00};
            end
        end
    end

`ifdef IFU_PERF_EN
    logic [31:0] r_retired_cnt;
    logic [31:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retired_cnt <= 32'd0;
            r_wait_cnt    <= 32'd0;
        end else begin
            if (r_state == S_VALID && advance) begin
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
            if (r_state == S_FETCH && !imem_ready) begin
                r_wait_cnt <= r_wait_cnt + 32'd1;
            end
        end
    end

    assign retired_cnt = r_retired_cnt;
    assign wait_cnt    = r_wait_cnt;
`endif

    assign imem_req    = (r_state == S_FETCH);
    assign instr_valid = (r_state == S_VALID);
    assign fetch_err   = (r_state == S_ERR);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign instr       = r_instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        advance;
    logic        branch;
    logic        jump;
    logic        zero;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;
`ifdef IFU_PERF_EN
    logic [31:0] retired_cnt;
    logic [31:0] wait_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .WAIT_MAX(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (advance),
        .branch     (branch),
        .jump       (jump),
        .zero       (zero),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
`ifdef IFU_PERF_EN
        .retired_cnt(retired_cnt),
        .wait_cnt   (wait_cnt),
`endif
        .fetch_err  (fetch_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one fetch at exp_addr after 'waits' not-ready cycles, then advance with the given flags.
    task automatic run_instr(input logic [31:0] exp_addr, input logic [31:0] data, input int waits,
                             input logic jp, input logic br, input logic z,
                             input logic [31:0] exp_next, input string name);
        for (int i = 0; i < waits; i++) begin
            n_total++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr || instr_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL %s wait%0d: req=%b addr=%h valid=%b want req=1 addr=%h valid=0",
                         name, i, imem_req, imem_addr, instr_valid, exp_addr);
            end
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            tick();
        end
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== exp_addr || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s fetch: req=%b addr=%h valid=%b want req=1 addr=%h valid=0",
                     name, imem_req, imem_addr, instr_valid, exp_addr);
        end
        imem_ready = 1'b1;
        imem_rdata = data;
        tick();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        n_total++;
        if (instr_valid !== 1'b1 || instr !== data || pc !== exp_addr || pc_plus4 !== exp_addr + 32'd4 ||
            imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL %s valid: valid=%b instr=%h pc=%h pc4=%h req=%b want 1 %h %h %h 0",
                     name, instr_valid, instr, pc, pc_plus4, imem_req, data, exp_addr, exp_addr + 32'd4);
        end
        advance = 1'b1;
        jump    = jp;
        branch  = br;
        zero    = z;
        tick();
        advance = 1'b0;
        jump    = 1'b0;
        branch  = 1'b0;
        zero    = 1'b0;
        n_total++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_next || pc[1:0] !== 2'b00) begin
            n_bad++;
            $display("FAIL %s next: valid=%b req=%b addr=%h want valid=0 req=1 addr=%h",
                     name, instr_valid, imem_req, imem_addr, exp_next);
        end
    endtask

    task automatic reset_and_boot();
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        advance    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        zero       = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        tick();
        tick();
        n_total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0 || pc !== 32'h0 ||
            instr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset: req=%b valid=%b err=%b pc=%h instr=%h want 0 0 0 0 0",
                     imem_req, instr_valid, fetch_err, pc, instr);
        end
        rst_n = 1'b1;
        tick();
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL boot: req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        run_instr(32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h4, "seq0");
        run_instr(32'h4, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h8, "seq1");
        run_instr(32'h8, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'hC, "seq2");
    endtask

    task automatic test_branch();
        run_instr(32'hC,  32'h0800_0008, 0, 1'b1, 1'b0, 1'b0, 32'h20, "jmp_to_20");
        run_instr(32'h20, 32'h1022_FFFE, 0, 1'b0, 1'b1, 1'b1, 32'h1C, "beq_taken");
        run_instr(32'h1C, 32'h0800_0008, 0, 1'b1, 1'b0, 1'b0, 32'h20, "jmp_back");
        run_instr(32'h20, 32'h1022_FFFE, 0, 1'b0, 1'b1, 1'b0, 32'h24, "beq_not_taken");
    endtask

    task automatic test_jump();
        run_instr(32'h24,        32'h0BFF_FFFF, 0, 1'b1, 1'b0, 1'b0, 32'h0FFF_FFFC, "jmp_max");
        run_instr(32'h0FFF_FFFC, 32'h0800_0010, 0, 1'b1, 1'b0, 1'b0, 32'h1000_0040, "jmp_region");
        run_instr(32'h1000_0040, 32'h0800_0010, 0, 1'b1, 1'b1, 1'b1, 32'h1000_0040, "jmp_over_br");
    endtask

    task automatic test_wait_states();
        run_instr(32'h1000_0040, 32'hA5A5_1234, 3, 1'b0, 1'b0, 1'b0, 32'h1000_0044, "wait3");
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (imem_req !== 1'b1 || fetch_err !== 1'b0 || imem_addr !== 32'h1000_0044) begin
                n_bad++;
                $display("FAIL timeout_pre%0d: req=%b err=%b addr=%h want 1 0 10000044",
                         i, imem_req, fetch_err, imem_addr);
            end
            imem_ready = 1'b0;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout_err%0d: err=%b req=%b valid=%b want 1 0 0",
                         i, fetch_err, imem_req, instr_valid);
            end
            imem_ready = 1'b1;
            advance    = 1'b1;
            tick();
        end
        imem_ready = 1'b0;
        advance    = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        reset_and_boot();
        run_instr(32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h4, "pre_rst");
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        n_total++;
        if (instr !== 32'h0 || instr_valid !== 1'b0 || pc !== 32'h0 || imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_fetch: instr=%h valid=%b pc=%h req=%b want 0 0 0 0",
                     instr, instr_valid, pc, imem_req);
        end
        rst_n      = 1'b1;
        imem_ready = 1'b0;
        tick();
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_restart: req=%b addr=%h instr=%h want 1 0 0", imem_req, imem_addr, instr);
        end
        run_instr(32'h0, 32'h1234_5678, 1, 1'b0, 1'b0, 1'b0, 32'h4, "post_rst");
    endtask

`ifdef IFU_PERF_EN
    task automatic test_perf();
        reset_and_boot();
        n_total++;
        if (retired_cnt !== 32'd0 || wait_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL perf_reset: retired=%0d wait=%0d want 0 0", retired_cnt, wait_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            run_instr(32'(i * 4), 32'h0, 2, 1'b0, 1'b0, 1'b0, 32'((i + 1) * 4), "perf");
        end
        n_total++;
        if (retired_cnt !== 32'd5 || wait_cnt !== 32'd10) begin
            n_bad++;
            $display("FAIL perf_counts: retired=%0d wait=%0d want 5 10", retired_cnt, wait_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_wait_states();
        test_timeout();
        test_reset_mid_fetch();
`ifdef IFU_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the single-cycle MIPS core; sits directly upstream of the main control decoder.
- Holds the PC and fetches one 32-bit instruction per step from instruction memory through a req/ready handshake.
- Presents the held instruction to decode/execute.
- On `advance`, computes the next PC from the decoder's `branch`/`jump` outputs and the ALU `zero` flag, then starts the next fetch.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address; must be word-aligned.
- WAIT_MAX, 16, max cycles `imem_req` may stay high without `imem_ready` before a fetch timeout (range 1..255).

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- advance  in  1  current instruction completes this cycle; update PC.
- branch  in  1  decoder branch flag for held instruction.
- jump  in  1  decoder jump flag for held instruction.
- zero  in  1  ALU zero flag for held instruction.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, equal to `pc`.
- imem_ready  in  1  memory data valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  held instruction; `opcode` = [31:26], `func` = [5:0].
- instr_valid  out  1  `instr` valid for decode.
- pc  out  32  address of the held/in-flight instruction.
- pc_plus4  out  32  `pc + 4`, modulo 2^32.
- fetch_err  out  1  sticky fetch timeout.

Behaviour:
- States: BOOT, FETCH, VALID, ERR.
- Reset (`rst_n` low at edge) forces:
  - state = BOOT, `pc` = RESET_PC, `instr` = 0, wait counter = 0.
  - Outputs: `instr_valid` = 0, `imem_req` = 0, `fetch_err` = 0.
  - Applies from any state, including mid-fetch.
  - A pending memory response arriving during or after reset is discarded.
- BOOT: next cycle goes to FETCH unconditionally.
- FETCH:
  - `imem_req` = 1 (decoded from state); `imem_addr` = `pc`, stable for the whole request.
  - If `imem_ready` is high at the edge: `instr` <= `imem_rdata`, go to VALID, clear the wait counter.
  - Otherwise increment the wait counter.
  - Timeout: if the counter reaches WAIT_MAX with `imem_ready` still low, go to ERR.
  - `advance` is ignored in FETCH.
- VALID:
  - `instr_valid` = 1, `imem_req` = 0; `instr` and `pc` held stable.
  - `advance` = 0: remain in VALID indefinitely (stall).
  - `advance` = 1: `pc` <= next_pc, go to FETCH; `instr_valid` drops the following cycle.
- next_pc, evaluated in the advance cycle, in priority order:
  - `jump` = 1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else `branch` & `zero`: pc_plus4 + (sign-extended instr[15:0] << 2).
  - else pc_plus4.
  - All additions are 32-bit, wrap modulo 2^32 with no overflow flag.
  - `jump` and `branch` both high: jump wins.
  - `branch` high with `zero` low: falls through to pc_plus4.
- ERR:
  - `fetch_err` = 1, `imem_req` = 0, `instr_valid` = 0.
  - Exited only by reset.
- Minimum step latency: one advance cycle to the first FETCH cycle; a zero-wait memory gives a VALID→FETCH→VALID loop of 2 cycles per instruction.
- `pc[1:0]` is always 2'b00.

Optional Feature:
- Macro IFU_PERF_EN.
- Defined:
  - Adds outputs `retired_cnt[31:0]` and `wait_cnt[31:0]`, both reset to 0 and wrapping at 2^32.
  - `retired_cnt` increments on each VALID cycle with `advance` = 1.
  - `wait_cnt` increments on each FETCH cycle with `imem_ready` = 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then zero-wait memory returning 32'h0000_0000 NOPs, `advance` pulsed in each VALID cycle → `imem_addr` sequence 0x0, 0x4, 0x8; `instr_valid` toggles 0/1 each cycle.
- At `pc` = 0x20, instr = BEQ with imm 16'hFFFE, `branch` = 1, `zero` = 1 → next `imem_addr` = 0x1C. Same with `zero` = 0 → 0x24.
- At `pc` = 0x1000_0040, instr[25:0] = 26'h0000010, `jump` = 1 and `branch` = 1 → next `pc` = 0x1000_0040.
- `imem_ready` delayed 3 cycles, with `imem_rdata` changing before ready → `imem_addr` stable throughout, `instr` equals the data sampled at the ready edge. With WAIT_MAX = 4 and ready never asserted → `fetch_err` = 1 after 4 FETCH cycles, `imem_req` = 0, held until reset.
- `rst_n` low during FETCH with `imem_ready` arriving in the same cycle → `instr` = 0, `instr_valid` = 0, `pc` = RESET_PC; the next fetch restarts at RESET_PC after BOOT.
- With IFU_PERF_EN: 5 retired instructions, each with 2 wait cycles → `retired_cnt` = 5, `wait_cnt` = 10.
